// File: rtl/pa_fetch.sv
// Instruction-fetch stage of the pa core: holds the PC, issues word fetches and latches the
// returned instruction for decode. Define PA_FETCH_MISALIGN_EN to trap misaligned redirect targets.
module pa_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl_pc_sel_i,
  input  logic        ctrl_stall_i,
  input  logic [31:0] branch_target_i,
  output logic        if_req_valid_o,
  output logic [31:0] if_req_addr_o,
  input  logic        if_resp_valid_i,
  input  logic [31:0] if_resp_data_i,
  output logic [31:0] if_stage_instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;

  logic        redir_acc;
  logic [31:0] tgt;
  logic        tgt_mis;
  logic [31:0] pc_inc;

  assign redir_acc = ctrl_pc_sel_i & ~ctrl_stall_i;
  assign pc_inc    = pc + 32'd4;

`ifdef PA_FETCH_MISALIGN_EN
  localparam logic [31:0] PC_EXCEPTION_ADDR = 32'h0000_8000;
  assign tgt_mis = |branch_target_i[1:0];
  assign tgt     = tgt_mis ? PC_EXCEPTION_ADDR : branch_target_i;
`else
  assign tgt_mis = 1'b0;
  assign tgt     = branch_target_i & ~32'h0000_0003;
`endif

  // Fetch FSM; every output is a register updated alongside the state transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc          <= PC_RESET_ADDR;
      req_valid   <= 1'b0;
      req_addr    <= 32'h0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          state     <= REQ;
          req_valid <= 1'b1;
          req_addr  <= pc;
        end
        REQ: begin
          if (redir_acc) begin
            pc       <= tgt;
            misalign <= tgt_mis;
            if (if_resp_valid_i) begin
              // Response belongs to the abandoned address; the bus is free, so re-issue at once.
              req_addr <= tgt;
            end else begin
              state     <= KILL;
              req_valid <= 1'b0;
              req_addr  <= 32'h0;
            end
          end else if (if_resp_valid_i) begin
            state       <= HOLD;
            instr       <= if_resp_data_i;
            instr_valid <= 1'b1;
            req_valid   <= 1'b0;
            req_addr    <= 32'h0;
          end else begin
            state <= REQ;
          end
        end
        HOLD: begin
          if (ctrl_stall_i) begin
            state <= HOLD;
          end else if (ctrl_pc_sel_i) begin
            state       <= REQ;
            pc          <= tgt;
            misalign    <= tgt_mis;
            req_valid   <= 1'b1;
            req_addr    <= tgt;
            instr_valid <= 1'b0;
          end else begin
            state       <= REQ;
            pc          <= pc_inc;
            req_valid   <= 1'b1;
            req_addr    <= pc_inc;
            instr_valid <= 1'b0;
          end
        end
        KILL: begin
          if (redir_acc) begin
            pc       <= tgt;
            misalign <= tgt_mis;
          end else begin
            pc <= pc;
          end
          if (if_resp_valid_i) begin
            state     <= REQ;
            req_valid <= 1'b1;
            req_addr  <= redir_acc ? tgt : pc;
          end else begin
            state <= KILL;
          end
        end
        default: begin
          state       <= IDLE;
          req_valid   <= 1'b0;
          req_addr    <= 32'h0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign if_req_valid_o   = req_valid;
  assign if_req_addr_o    = req_addr;
  assign if_stage_instr_o = instr;
  assign instr_valid_o    = instr_valid;
  assign pc_o             = pc;
  assign misalign_o       = misalign;

endmodule

// File: tb/tb_pa_fetch.sv
// Directed self-checking bench for pa_fetch with a k-cycle-latency memory model.
module tb_pa_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_sel = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] target = 32'h0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        misalign;

  int          checks = 0;
  int          errors = 0;

  // memory model state
  int          k = 1;
  int          cnt = 0;
  logic        pending = 1'b0;
  logic [31:0] paddr = 32'h0;

  logic [31:0] mis_addr;
  logic        mis_exp;

  pa_fetch dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ctrl_pc_sel_i   (pc_sel),
    .ctrl_stall_i    (stall),
    .branch_target_i (target),
    .if_req_valid_o  (req_valid),
    .if_req_addr_o   (req_addr),
    .if_resp_valid_i (resp_valid),
    .if_resp_data_i  (resp_data),
    .if_stage_instr_o(instr),
    .instr_valid_o   (instr_valid),
    .pc_o            (pc),
    .misalign_o      (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, then advance the memory model.
  task automatic tick();
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    if (pending) begin
      cnt++;
      if (cnt >= k) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(paddr);
        pending    = 1'b0;
      end
    end else if (req_valid && !rst) begin
      pending = 1'b1;
      cnt     = 0;
      paddr   = req_addr;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = instr_valid;
    end
    chk(tag, {31'h0, seen}, 32'h1);
  endtask

  initial begin
`ifdef PA_FETCH_MISALIGN_EN
    mis_addr = 32'h0000_8000;
    mis_exp  = 1'b1;
`else
    mis_addr = 32'h0000_2000;
    mis_exp  = 1'b0;
`endif
    // reset state
    tick();
    tick();
    chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc", pc, 32'h0000_1000);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);

    // first fetch, k=1
    rst = 1'b0;
    tick();
    chk("first_req_valid", {31'h0, req_valid}, 32'h1);
    chk("first_req_addr", req_addr, 32'h0000_1000);
    tick();
    chk("first_not_yet_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("first_instr_valid", {31'h0, instr_valid}, 32'h1);
    chk("first_instr", instr, mem_word(32'h0000_1000));
    chk("hold_no_req", {31'h0, req_valid}, 32'h0);

    // stall in HOLD for 5 cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", instr, mem_word(32'h0000_1000));
      chk("stall_pc", pc, 32'h0000_1000);
      chk("stall_no_req", {31'h0, req_valid}, 32'h0);
    end
    stall = 1'b0;
    k = 3;
    tick();
    chk("seq_req_valid", {31'h0, req_valid}, 32'h1);
    chk("seq_req_addr", req_addr, 32'h0000_1004);

    // redirect while the request is outstanding -> KILL, drain stale response
    pc_sel = 1'b1;
    target = 32'h0000_2000;
    tick();
    pc_sel = 1'b0;
    chk("kill_no_req", {31'h0, req_valid}, 32'h0);
    chk("kill_pc", pc, 32'h0000_2000);
    tick();
    tick();
    chk("kill_stale_resp_seen", {31'h0, resp_valid}, 32'h1);
    tick();
    chk("kill_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("after_kill_req_valid", {31'h0, req_valid}, 32'h1);
    chk("after_kill_req_addr", req_addr, 32'h0000_2000);
    wait_valid("wait_2000", 10);
    chk("redir_instr", instr, mem_word(32'h0000_2000));
    chk("redir_pc", pc, 32'h0000_2000);

    // pc_sel under stall is ignored until stall drops
    k = 1;
    stall = 1'b1;
    pc_sel = 1'b1;
    target = 32'h0000_3000;
    tick();
    tick();
    chk("stall_sel_pc", pc, 32'h0000_2000);
    chk("stall_sel_valid", {31'h0, instr_valid}, 32'h1);
    chk("stall_sel_no_req", {31'h0, req_valid}, 32'h0);
    stall = 1'b0;
    tick();
    pc_sel = 1'b0;
    chk("sel_req_addr", req_addr, 32'h0000_3000);
    chk("sel_instr_dropped", {31'h0, instr_valid}, 32'h0);

    // redirect to a misaligned target coinciding with the response
    tick();
    chk("coincide_resp", {31'h0, resp_valid}, 32'h1);
    pc_sel = 1'b1;
    target = 32'h0000_2002;
    tick();
    pc_sel = 1'b0;
    chk("coincide_req_valid", {31'h0, req_valid}, 32'h1);
    chk("coincide_req_addr", req_addr, mis_addr);
    chk("misalign_pulse", {31'h0, misalign}, {31'h0, mis_exp});
    tick();
    chk("misalign_one_cycle", {31'h0, misalign}, 32'h0);
    tick();
    chk("coincide_instr", instr, mem_word(mis_addr));
    chk("coincide_valid", {31'h0, instr_valid}, 32'h1);

    // pc wraps from 0xFFFF_FFFC to 0
    pc_sel = 1'b1;
    target = 32'hFFFF_FFFC;
    tick();
    pc_sel = 1'b0;
    chk("top_req_addr", req_addr, 32'hFFFF_FFFC);
    wait_valid("wait_top", 10);
    chk("top_instr", instr, mem_word(32'hFFFF_FFFC));
    tick();
    chk("wrap_req_addr", req_addr, 32'h0000_0000);
    chk("wrap_pc", pc, 32'h0000_0000);

    // reset in the middle of a request
    rst = 1'b1;
    pending = 1'b0;
    tick();
    chk("midrst_req_valid", {31'h0, req_valid}, 32'h0);
    chk("midrst_pc", pc, 32'h0000_1000);
    chk("midrst_instr", instr, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_req_valid", {31'h0, req_valid}, 32'h1);
    chk("post_rst_req_addr", req_addr, 32'h0000_1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
